instr_encode_loader: RTL and testbench



---
 rtl/instr_encode_loader.sv | 150 +++++++++++++++
 tb/tb_instr_encode_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encode_loader.sv
// rtl/instr_encode_loader.sv - encodes RV32I instruction fields and streams them into instruction memory
// Accepts one field set per two cycles, checks it, and writes the encoded word at the running pointer.
module instr_encode_loader #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_class,
   input  logic [2:0]        in_funct3,
   input  logic              in_f7b5,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [12:0]       in_imm,
   input  logic              in_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   instr_count
);

   typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_B    = 7'b1100011;

   localparam logic [ADDR_W-1:0] PTR_ONE = 1;
   localparam logic [ADDR_W:0]   CNT_ONE = 1;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] ptr_next;
   logic              last_q;
   logic [31:0]       enc_word;
   logic [1:0]        enc_err;
   logic              imm_fits12;

   assign imm_fits12 = (in_imm[12] == in_imm[11]);
   assign ptr_next   = ptr + PTR_ONE;

   // Unused fields for a class never reach the word, so they need no masking.
   always_comb begin
      enc_word = 32'd0;
      enc_err  = 2'b00;
      case (in_class)
         3'b000: enc_word = {1'b0, in_f7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
         3'b001: begin
            if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
               enc_word = {1'b0, in_f7b5 & in_funct3[2], 5'b00000, in_imm[4:0],
                           in_rs1, in_funct3, in_rd, OP_I};
               if (in_imm[12:5] != 8'd0) enc_err = 2'b10;
            end else begin
               enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
               if (!imm_fits12) enc_err = 2'b10;
            end
         end
         3'b010: begin
            enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
            if (!imm_fits12) enc_err = 2'b10;
         end
         3'b011: begin
            enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_S};
            if (!imm_fits12) enc_err = 2'b10;
         end
         3'b100: begin
            enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], OP_B};
            if (in_imm[0]) enc_err = 2'b10;
         end
         default: enc_err = 2'b01;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= '0;
         last_q      <= 1'b0;
         in_ready    <= 1'b0;
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= 32'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err_code    <= 2'b00;
         instr_count <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= ACCEPT;
                  ptr         <= '0;
                  instr_count <= '0;
                  err_code    <= 2'b00;
                  done        <= 1'b0;
                  in_ready    <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            ACCEPT: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  if (enc_err != 2'b00) begin
                     state    <= DONE;
                     err_code <= enc_err;
                     done     <= 1'b1;
                     busy     <= 1'b0;
                  end else begin
                     state      <= WRITE;
                     imem_we    <= 1'b1;
                     imem_addr  <= ptr;
                     imem_wdata <= enc_word;
                     last_q     <= in_last;
                  end
               end
            end
            WRITE: begin
               imem_we     <= 1'b0;
               ptr         <= ptr_next;
               instr_count <= instr_count + CNT_ONE;
               if (last_q) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else if (ptr_next == '0) begin
                  // Memory is full; stop rather than overwrite word 0.
                  state    <= DONE;
                  err_code <= 2'b11;
                  done     <= 1'b1;
                  busy     <= 1'b0;
               end else begin
                  state    <= ACCEPT;
                  in_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encode_loader.sv
// tb/tb_instr_encode_loader.sv - scoreboard bench for instr_encode_loader
// Expected writes and final status come from a behavioural encoder model over whole programs.
module tb_instr_encode_loader;

   localparam int AW    = 2;
   localparam int DEPTH = 1 << AW;

   typedef struct {
      logic [2:0]  cls;
      logic [2:0]  f3;
      logic        f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [12:0] imm;
      logic        last;
   } instr_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   typedef struct {
      logic [1:0]  err;
      logic [31:0] cnt;
   } st_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    in_class = '0;
   logic [2:0]    in_funct3 = '0;
   logic          in_f7b5 = 1'b0;
   logic [4:0]    in_rd = '0;
   logic [4:0]    in_rs1 = '0;
   logic [4:0]    in_rs2 = '0;
   logic [12:0]   in_imm = '0;
   logic          in_last = 1'b0;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          busy;
   logic          done;
   logic [1:0]    err_code;
   logic [AW:0]   instr_count;

   int n_cmp = 0;
   int n_fail = 0;

   instr_t prog[$];
   wr_t    exp_wr[$];
   st_t    exp_st[$];

   always #5 clk = ~clk;

   instr_encode_loader #(.ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_class(in_class), .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_rd(in_rd),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
      .done(done), .err_code(err_code), .instr_count(instr_count)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic instr_t mk(input int cls, input int f3, input int f7, input int rd,
                                 input int rs1, input int rs2, input int imm, input int last);
      instr_t t;
      t.cls = 3'(cls); t.f3 = 3'(f3); t.f7 = 1'(f7); t.rd = 5'(rd);
      t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.imm = 13'(imm); t.last = 1'(last);
      return t;
   endfunction

   // Reference encoder: range checks on the signed integer value, fields placed by arithmetic.
   function automatic void model_enc(input instr_t t, output logic [1:0] e, output logic [31:0] w);
      int   s;
      logic [31:0] common;
      s = int'($signed(t.imm));
      e = 2'b00;
      w = 32'd0;
      common = (32'(t.rs1) << 15) | (32'(t.f3) << 12);
      case (int'(t.cls))
         0: w = (32'(t.f7) << 30) | (32'(t.rs2) << 20) | common | (32'(t.rd) << 7) | 32'h33;
         1, 2: begin
            if (t.cls == 3'd1 && (t.f3 == 3'd1 || t.f3 == 3'd5)) begin
               if (s < 0 || s > 31) e = 2'b10;
               w = ((t.f3 == 3'd5) ? (32'(t.f7) << 30) : 32'd0) | (32'(s & 31) << 20)
                   | common | (32'(t.rd) << 7) | 32'h13;
            end else begin
               if (s < -2048 || s > 2047) e = 2'b10;
               w = (32'(s & 4095) << 20) | common | (32'(t.rd) << 7)
                   | ((t.cls == 3'd1) ? 32'h13 : 32'h03);
            end
         end
         3: begin
            if (s < -2048 || s > 2047) e = 2'b10;
            w = (32'((s >> 5) & 127) << 25) | (32'(t.rs2) << 20) | common
                | (32'(s & 31) << 7) | 32'h23;
         end
         4: begin
            if (s % 2 != 0) e = 2'b10;
            w = (32'((s >> 12) & 1) << 31) | (32'((s >> 5) & 63) << 25) | (32'(t.rs2) << 20)
                | common | (32'((s >> 1) & 15) << 8) | (32'((s >> 11) & 1) << 7) | 32'h63;
         end
         default: e = 2'b01;
      endcase
   endfunction

   // Walk the program as the loader should; returns how many field sets get accepted.
   task automatic model_prog(output int n_acc, output bit ovf);
      int ptr = 0;
      logic [1:0] err = 2'b00;
      logic [1:0] e;
      logic [31:0] w;
      wr_t wr;
      st_t st;
      n_acc = 0;
      ovf = 0;
      foreach (prog[i]) begin
         model_enc(prog[i], e, w);
         n_acc++;
         if (e != 2'b00) begin err = e; break; end
         wr.addr = AW'(ptr); wr.data = w;
         exp_wr.push_back(wr);
         ptr++;
         if (prog[i].last) break;
         if (ptr == DEPTH) begin err = 2'b11; ovf = 1; break; end
      end
      st.err = err; st.cnt = 32'(ptr);
      exp_st.push_back(st);
   endtask

   task automatic drive_fields(input instr_t t);
      in_class = t.cls; in_funct3 = t.f3; in_f7b5 = t.f7; in_rd = t.rd;
      in_rs1 = t.rs1; in_rs2 = t.rs2; in_imm = t.imm; in_last = t.last;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic offer(input instr_t t, output bit ok);
      drive_fields(t);
      in_valid = 1'b1;
      ok = 0;
      for (int k = 0; k < 40; k++) begin
         if (in_ready) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_prog(input bit gaps);
      int n_acc;
      bit ovf;
      bit ok;
      bit seen;
      model_prog(n_acc, ovf);
      pulse_start();
      for (int i = 0; i < n_acc; i++) begin
         offer(prog[i], ok);
         if (!ok) begin in_valid = 1'b0; return; end
         @(negedge clk);
         in_valid = 1'b0;
         drive_fields(mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom));
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      if (ovf && n_acc < prog.size()) begin
         drive_fields(prog[n_acc]);
         in_valid = 1'b1;
         seen = 0;
         repeat (6) begin @(negedge clk); if (in_ready) seen = 1; end
         check("overflow_refuses_more", 32'(seen), 32'd0);
         in_valid = 1'b0;
      end
      ok = 0;
      for (int k = 0; k < 40; k++) begin
         if (done) begin ok = 1; break; end
         @(negedge clk);
      end
      check("done_reached", 32'(ok), 32'd1);
      @(negedge clk);
   endtask

   // Monitor: pops the scoreboard whenever a write strobe or a fresh done appears.
   initial begin
      logic done_prev = 1'b0;
      logic we_prev = 1'b0;
      wr_t w;
      st_t s;
      forever begin
         @(negedge clk);
         if (imem_we) begin
            check("we_single_cycle", 32'(we_prev), 32'd0);
            if (exp_wr.size() == 0) check("unexpected_write", 32'd1, 32'd0);
            else begin
               w = exp_wr.pop_front();
               check("wr_addr", 32'(imem_addr), 32'(w.addr));
               check("wr_data", imem_wdata, w.data);
            end
         end
         if (done && !done_prev) begin
            if (exp_st.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else begin
               s = exp_st.pop_front();
               check("err_code", 32'(err_code), 32'(s.err));
               check("instr_count", 32'(instr_count), s.cnt);
               check("busy_at_done", 32'(busy), 32'd0);
               check("ready_at_done", 32'(in_ready), 32'd0);
               if (exp_wr.size() != 0) check("writes_missing", 32'(exp_wr.size()), 32'd0);
            end
         end
         done_prev = done;
         we_prev = imem_we;
      end
   end

   initial begin
      bit ok;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_we", 32'(imem_we), 32'd0);
      check("rst_addr_data", {imem_wdata[29:0], imem_addr}, 32'd0);
      check("rst_status", {busy, done, err_code, 28'(instr_count)}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_ready", 32'(in_ready), 32'd0);

      prog = {mk(0, 0, 0, 3, 1, 2, 0, 1)};
      run_prog(0);
      prog = {mk(3, 2, 0, 0, 2, 5, 8, 0), mk(4, 0, 0, 0, 1, 2, -8, 1)};
      run_prog(0);
      prog = {mk(1, 5, 1, 4, 4, 0, 3, 1)};
      run_prog(0);
      prog = {mk(4, 0, 0, 0, 1, 2, 5, 1)};
      run_prog(0);
      prog = {mk(7, 0, 0, 1, 1, 1, 0, 1)};
      run_prog(0);
      prog = {mk(0, 0, 0, 1, 2, 3, 0, 0), mk(1, 0, 0, 2, 3, 0, -1, 0), mk(2, 2, 0, 3, 4, 0, 100, 0),
              mk(3, 2, 0, 0, 5, 6, -4, 0), mk(0, 7, 0, 9, 9, 9, 0, 0)};
      run_prog(0);

      for (int p = 0; p < 40; p++) begin
         int len = $urandom_range(1, 6);
         prog.delete();
         for (int i = 0; i < len; i++) begin
            int cls = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
            int imm = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8191) : $urandom_range(0, 40) - 20;
            if (cls == 4 && $urandom_range(0, 3) != 0) imm = imm & ~1;
            prog.push_back(mk(cls, $urandom, $urandom, $urandom, $urandom, $urandom, imm, i == len - 1));
         end
         run_prog(1);
      end

      // Reset while the write strobe is up: that word is abandoned, then a fresh load starts at 0.
      pulse_start();
      offer(mk(0, 0, 0, 7, 7, 7, 0, 1), ok);
      @(posedge clk); #2;
      check("we_before_reset", 32'(imem_we), 32'd1);
      rst_n = 1'b0; #1;
      check("reset_kills_we", 32'(imem_we), 32'd0);
      check("reset_outputs", {27'(instr_count), busy, done, err_code, in_ready}, 32'd0);
      check("reset_addr_data", {imem_wdata[29:0], imem_addr}, 32'd0);
      in_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      check("no_resume", {31'd0, busy}, 32'd0);
      prog = {mk(2, 2, 0, 5, 6, 0, -12, 0), mk(0, 0, 1, 1, 2, 3, 0, 1)};
      run_prog(0);

      repeat (4) @(negedge clk);
      check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
      check("st_queue_empty", 32'(exp_st.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
